// File: rtl/command_initiator.sv
// command_initiator
//   Host-side register command initiator. Accepts read/write requests from a
//   local master, serializes them into a command byte {4'b0, addr, rw} plus an
//   optional write-data byte toward a UART TX, and for reads waits for a single
//   response byte from the UART RX.
//
//   Optional feature macro: COMMAND_INITIATOR_TIMEOUT_EN
//     defined   : read responses are bounded by TIMEOUT_CYCLES wait cycles
//     undefined : reads wait indefinitely, o_rsp_timeout is tied to 0
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req_valid/o_req_ready, i_req_rw, i_req_addr, i_req_wdata
//                         request handshake and payload (rw: 1 = write)
//   o_tx_data, o_tx_data_valid, i_tx_ready
//                         byte stream to the UART transmitter
//   i_rx_data, i_rx_data_valid
//                         response byte strobe from the UART receiver
//   o_rsp_valid, o_rsp_data, o_rsp_timeout
//                         single-cycle completion with read data / timeout flag
module command_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rw,
  input  logic [2:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic [7:0] o_tx_data,
  output logic       o_tx_data_valid,
  input  logic       i_tx_ready,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_data_valid,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_timeout
);

  // Reject illegal timeout settings at elaboration.
  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("command_initiator: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_SEND_DATA,
    S_WAIT_RSP,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic       rw_q, rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       tx_fire;

`ifdef COMMAND_INITIATOR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  assign tx_fire = tx_valid_q & i_tx_ready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef COMMAND_INITIATOR_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_req_valid && req_ready_q) begin
          rw_d        = i_req_rw;
          wdata_d     = i_req_wdata;
          tx_data_d   = {4'b0000, i_req_addr, i_req_rw};
          tx_valid_d  = 1'b1;
          req_ready_d = 1'b0;
          // Previous response is held until the next accept clears it.
          rsp_data_d  = 8'h00;
`ifdef COMMAND_INITIATOR_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d     = S_SEND_CMD;
        end
      end

      S_SEND_CMD: begin
        if (tx_fire) begin
          if (rw_q) begin
            tx_data_d = wdata_q;
            state_d   = S_SEND_DATA;
          end else begin
            tx_valid_d = 1'b0;
`ifdef COMMAND_INITIATOR_TIMEOUT_EN
            cnt_d      = '0;
`endif
            state_d    = S_WAIT_RSP;
          end
        end
      end

      S_SEND_DATA: begin
        if (tx_fire) begin
          tx_valid_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_WAIT_RSP: begin
        // Response data takes priority over a timeout on the same cycle.
        if (i_rx_data_valid) begin
          rsp_data_d  = i_rx_data;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end
`ifdef COMMAND_INITIATOR_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_DONE: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        tx_valid_d  = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      wdata_q     <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef COMMAND_INITIATOR_TIMEOUT_EN
  // Read-response timeout counter and flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign o_rsp_timeout = rsp_timeout_q;
`else
  assign o_rsp_timeout = 1'b0;
`endif

  assign o_req_ready     = req_ready_q;
  assign o_tx_data       = tx_data_q;
  assign o_tx_data_valid = tx_valid_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_data      = rsp_data_q;

endmodule

// File: tb/tb_command_initiator.sv
// tb_command_initiator
//   Self-checking bench for command_initiator. Inputs are driven at the
//   falling edge; a monitor samples outputs 1 time unit later and logs every
//   TX transfer and response pulse with its cycle index.
module tb_command_initiator;

  localparam int unsigned TO = 8;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         rsp_cnt      = 0;
  logic [7:0] rsp_d_last   = 8'h00;
  logic       rsp_to_last  = 1'b0;
  int         rsp_cyc_last = 0;
  logic       held         = 1'b0;
  logic [7:0] held_byte    = 8'h00;
  int         stable_bad   = 0;
  logic       rdy_prev     = 1'b1;
  int         rdy_cyc      = 0;
  logic       rand_ready   = 1'b0;

  command_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_rw        (req_rw),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_tx_data       (tx_data),
    .o_tx_data_valid (tx_valid),
    .i_tx_ready      (tx_ready),
    .i_rx_data       (rx_data),
    .i_rx_data_valid (rx_valid),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_data      (rsp_data),
    .o_rsp_timeout   (rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one sample per cycle, after the falling-edge drive has settled.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (tx_valid && tx_ready) begin
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_d_last   = rsp_data;
      rsp_to_last  = rsp_timeout;
      rsp_cyc_last = cyc;
    end
    if (held && tx_valid && (tx_data !== held_byte)) stable_bad++;
    held      = tx_valid && !tx_ready;
    held_byte = tx_data;
    if (req_ready && !rdy_prev) rdy_cyc = cyc;
    rdy_prev = req_ready;
  end

  always @(negedge clk) if (rand_ready) tx_ready = 1'($urandom_range(0, 1));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rule for the command byte.
  function automatic logic [7:0] cmd_byte(input logic rw, input logic [2:0] a);
    return {4'b0000, a, rw};
  endfunction

  // Present a request until accepted; acc is the cycle whose closing edge accepts.
  task automatic issue(input logic rw, input logic [2:0] a, input logic [7:0] wd,
                       output int acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 300 && acc < 0; i++) begin
      #2;
      if (req_ready) acc = cyc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_addr  = 3'($urandom);
    req_wdata = 8'($urandom);
  endtask

  // Wait until n bytes have been transferred; returns at the next cycle start.
  task automatic wait_tx(input int n);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #2;
      seen = (tx_log.size() >= n);
      @(negedge clk);
    end
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 3'd0; req_wdata = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if ({req_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_timeout} !== 20'h80000) begin
      n_bad++;
      $display("FAIL reset_values: got %h expected %h",
               {req_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_timeout}, 20'h80000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read(input logic [2:0] a, input logic [7:0] rxb, input int d);
    int acc, n0, r0, m;
    logic [7:0] got;
    tx_ready = 1'b1; n0 = tx_log.size(); r0 = rsp_cnt;
    issue(1'b0, a, 8'($urandom), acc);
    wait_tx(n0 + 1);
    repeat (d) @(negedge clk);
    m = cyc + 1;
    pulse_rx(rxb);
    repeat (4) @(negedge clk);
    #2;
    got = (tx_log.size() > n0) ? tx_log[n0] : 8'hxx;
    n_cmp++;
    if (tx_log.size() !== n0 + 1 || got !== cmd_byte(1'b0, a)) begin
      n_bad++; $display("FAIL read_tx: got %0d bytes first %h expected 1 byte %h",
                        tx_log.size() - n0, got, cmd_byte(1'b0, a));
    end
    n_cmp++;
    if (tx_log.size() > n0 && tx_cyc[n0] !== acc + 1) begin
      n_bad++; $display("FAIL read_tx_cycle: got %0d expected %0d", tx_cyc[n0], acc + 1);
    end
    n_cmp++;
    if (rsp_cnt - r0 !== 1 || rsp_d_last !== rxb || rsp_to_last !== 1'b0) begin
      n_bad++; $display("FAIL read_rsp: got n=%0d data=%h to=%b expected n=1 data=%h to=0",
                        rsp_cnt - r0, rsp_d_last, rsp_to_last, rxb);
    end
    n_cmp++;
    if (rsp_cyc_last !== m + 1) begin
      n_bad++; $display("FAIL read_rsp_cycle: got %0d expected %0d", rsp_cyc_last, m + 1);
    end
    n_cmp++;
    if (rsp_data !== rxb || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL read_rsp_hold: got %h/%b expected %h/0", rsp_data, rsp_valid, rxb);
    end
  endtask

  task automatic test_write(input logic [2:0] a, input logic [7:0] wd);
    int acc, n0, r0;
    tx_ready = 1'b1; n0 = tx_log.size(); r0 = rsp_cnt;
    issue(1'b1, a, wd, acc);
    #2;
    n_cmp++;
    if (rsp_data !== 8'h00 || rsp_timeout !== 1'b0 || tx_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL write_accept: got data=%h to=%b txv=%b rdy=%b expected 00/0/1/0",
                        rsp_data, rsp_timeout, tx_valid, req_ready);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (tx_log.size() !== n0 + 2 || tx_log[n0] !== cmd_byte(1'b1, a) || tx_log[n0+1] !== wd) begin
      n_bad++; $display("FAIL write_tx: got %0d bytes expected %h %h",
                        tx_log.size() - n0, cmd_byte(1'b1, a), wd);
    end else begin
      n_cmp++;
      if (tx_cyc[n0] !== acc + 1 || tx_cyc[n0+1] !== acc + 2) begin
        n_bad++; $display("FAIL write_tx_cycles: got %0d %0d expected %0d %0d",
                          tx_cyc[n0], tx_cyc[n0+1], acc + 1, acc + 2);
      end
    end
    n_cmp++;
    if (rsp_cnt - r0 !== 1 || rsp_cyc_last !== acc + 3 || rsp_d_last !== 8'h00 ||
        rsp_to_last !== 1'b0) begin
      n_bad++; $display("FAIL write_rsp: got n=%0d cyc=%0d data=%h expected n=1 cyc=%0d data=00",
                        rsp_cnt - r0, rsp_cyc_last, rsp_d_last, acc + 3);
    end
    n_cmp++;
    if (rdy_cyc !== acc + 4) begin
      n_bad++; $display("FAIL write_ready_return: got %0d expected %0d", rdy_cyc, acc + 4);
    end
  endtask

  task automatic test_backpressure(input logic [2:0] a, input logic [7:0] wd);
    int acc, n0, r0, s0;
    tx_ready = 1'b0; n0 = tx_log.size(); r0 = rsp_cnt; s0 = stable_bad;
    issue(1'b1, a, wd, acc);
    repeat (5) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (5) @(negedge clk);
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (tx_log.size() !== n0 + 2 || tx_log[n0] !== cmd_byte(1'b1, a) || tx_log[n0+1] !== wd) begin
      n_bad++; $display("FAIL bp_tx: got %0d bytes expected %h %h",
                        tx_log.size() - n0, cmd_byte(1'b1, a), wd);
    end else begin
      n_cmp++;
      if (tx_cyc[n0] !== acc + 6 || tx_cyc[n0+1] !== acc + 12) begin
        n_bad++; $display("FAIL bp_tx_cycles: got %0d %0d expected %0d %0d",
                          tx_cyc[n0], tx_cyc[n0+1], acc + 6, acc + 12);
      end
    end
    n_cmp++;
    if (stable_bad !== s0) begin
      n_bad++; $display("FAIL bp_stable: got %0d changes expected 0", stable_bad - s0);
    end
    n_cmp++;
    if (rsp_cnt - r0 !== 1 || rsp_cyc_last !== acc + 13) begin
      n_bad++; $display("FAIL bp_rsp: got n=%0d cyc=%0d expected n=1 cyc=%0d",
                        rsp_cnt - r0, rsp_cyc_last, acc + 13);
    end
  endtask

  task automatic test_stray_rx();
    int acc, r0, m;
    tx_ready = 1'b0; r0 = rsp_cnt;
    @(negedge clk);
    pulse_rx(8'h55);
    issue(1'b0, 3'd5, 8'h00, acc);
    pulse_rx(8'h55);
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rsp_cnt !== r0) begin
      n_bad++; $display("FAIL stray_ignored: got %0d responses expected 0", rsp_cnt - r0);
    end
    m = cyc + 1;
    pulse_rx(8'h12);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rsp_cnt - r0 !== 1 || rsp_d_last !== 8'h12 || rsp_cyc_last !== m + 1) begin
      n_bad++; $display("FAIL stray_rsp: got n=%0d data=%h cyc=%0d expected n=1 data=12 cyc=%0d",
                        rsp_cnt - r0, rsp_d_last, rsp_cyc_last, m + 1);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, n0, r0, r1;
    tx_ready = 1'b0; n0 = tx_log.size(); r0 = rsp_cnt;
    issue(1'b1, 3'd6, 8'h3C, acc1);
    fork
      begin repeat (3) @(negedge clk); tx_ready = 1'b1; end
      issue(1'b1, 3'd2, 8'hC3, acc2);
    join
    r1 = rsp_cyc_last;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (acc2 !== r1 + 1) begin
      n_bad++; $display("FAIL busy_accept: got cycle %0d expected %0d", acc2, r1 + 1);
    end
    n_cmp++;
    if (tx_log.size() !== n0 + 4 || tx_log[n0] !== 8'h0D || tx_log[n0+1] !== 8'h3C ||
        tx_log[n0+2] !== 8'h05 || tx_log[n0+3] !== 8'hC3 || rsp_cnt - r0 !== 2) begin
      n_bad++; $display("FAIL busy_stream: got %0d bytes %0d rsps expected 4 bytes 2 rsps",
                        tx_log.size() - n0, rsp_cnt - r0);
    end
  endtask

  task automatic test_timeout();
    int acc, r0, m;
    tx_ready = 1'b1; r0 = rsp_cnt;
`ifdef COMMAND_INITIATOR_TIMEOUT_EN
    issue(1'b0, 3'd3, 8'h00, acc);
    repeat (TO + 6) @(negedge clk);
    #2;
    n_cmp++;
    if (rsp_cnt - r0 !== 1 || rsp_to_last !== 1'b1 || rsp_d_last !== 8'h00 ||
        rsp_cyc_last !== acc + 2 + int'(TO) || rsp_timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_fire: got n=%0d to=%b data=%h cyc=%0d expected n=1 to=1 data=00 cyc=%0d",
                        rsp_cnt - r0, rsp_to_last, rsp_d_last, rsp_cyc_last, acc + 2 + int'(TO));
    end
    r0 = rsp_cnt;
    issue(1'b0, 3'd4, 8'h00, acc);
    #2;
    n_cmp++;
    if (rsp_timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear: got %b expected 0", rsp_timeout);
    end
    repeat (TO) @(negedge clk);
    m = cyc + 1;
    pulse_rx(8'hE7);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rsp_cnt - r0 !== 1 || rsp_to_last !== 1'b0 || rsp_d_last !== 8'hE7 ||
        m !== acc + 1 + int'(TO) || rsp_cyc_last !== m + 1) begin
      n_bad++; $display("FAIL timeout_last_rx: got n=%0d to=%b data=%h cyc=%0d expected n=1 to=0 data=e7 cyc=%0d",
                        rsp_cnt - r0, rsp_to_last, rsp_d_last, rsp_cyc_last, m + 1);
    end
`else
    issue(1'b0, 3'd3, 8'h00, acc);
    repeat (40) @(negedge clk);
    #2;
    n_cmp++;
    if (rsp_cnt !== r0 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL no_timeout_wait: got n=%0d rdy=%b expected n=0 rdy=0",
                        rsp_cnt - r0, req_ready);
    end
    @(negedge clk);
    m = cyc + 1;
    pulse_rx(8'h3C);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rsp_cnt - r0 !== 1 || rsp_to_last !== 1'b0 || rsp_d_last !== 8'h3C ||
        rsp_cyc_last !== m + 1 || acc < 0) begin
      n_bad++; $display("FAIL no_timeout_rsp: got n=%0d to=%b data=%h expected n=1 to=0 data=3c",
                        rsp_cnt - r0, rsp_to_last, rsp_d_last);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int acc, n0, r0;
    // Abort in SEND_DATA.
    tx_ready = 1'b1; n0 = tx_log.size(); r0 = rsp_cnt;
    issue(1'b1, 3'd7, 8'h99, acc);
    @(negedge clk);
    tx_ready = 1'b0;
    #2; rst = 1'b1; #1;
    n_cmp++;
    if ({req_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_timeout} !== 20'h80000) begin
      n_bad++; $display("FAIL abort_data_values: got %h expected %h",
                        {req_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_timeout}, 20'h80000);
    end
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (tx_log.size() !== n0 + 1 || rsp_cnt !== r0) begin
      n_bad++; $display("FAIL abort_data_quiet: got %0d bytes %0d rsps expected 1 byte 0 rsps",
                        tx_log.size() - n0, rsp_cnt - r0);
    end
    // Abort in WAIT_RSP, then a late rx byte must be ignored.
    issue(1'b0, 3'd1, 8'h00, acc);
    @(negedge clk);
    #2; rst = 1'b1; #1;
    n_cmp++;
    if ({req_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_timeout} !== 20'h80000) begin
      n_bad++; $display("FAIL abort_wait_values: got %h expected %h",
                        {req_ready, tx_data, tx_valid, rsp_valid, rsp_data, rsp_timeout}, 20'h80000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_rx(8'h77);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (rsp_cnt !== r0) begin
      n_bad++; $display("FAIL abort_wait_quiet: got %0d rsps expected 0", rsp_cnt - r0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_tx[$];
    int n0, r0, k0, acc, bad_rsp;
    logic rw;
    logic [2:0] a;
    logic [7:0] wd, rxb;
    bit stream_ok;
    n0 = tx_log.size(); bad_rsp = 0;
    rand_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      rw = 1'($urandom); a = 3'($urandom); wd = 8'($urandom); rxb = 8'($urandom);
      r0 = rsp_cnt; k0 = tx_log.size();
      exp_tx.push_back(cmd_byte(rw, a));
      if (rw) exp_tx.push_back(wd);
      issue(rw, a, wd, acc);
      if (!rw) begin
        wait_tx(k0 + 1);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        pulse_rx(rxb);
      end
      for (int i = 0; i < 100 && rsp_cnt == r0; i++) @(negedge clk);
      n_cmp++;
      if (rsp_cnt - r0 !== 1 || rsp_d_last !== (rw ? 8'h00 : rxb) || rsp_to_last !== 1'b0) begin
        n_bad++; bad_rsp++;
        $display("FAIL random_rsp[%0d]: got n=%0d data=%h to=%b expected n=1 data=%h to=0",
                 t, rsp_cnt - r0, rsp_d_last, rsp_to_last, rw ? 8'h00 : rxb);
      end
    end
    rand_ready = 1'b0;
    tx_ready   = 1'b1;
    repeat (3) @(negedge clk);
    stream_ok = (tx_log.size() == n0 + exp_tx.size());
    for (int i = 0; i < exp_tx.size() && stream_ok; i++)
      if (tx_log[n0+i] !== exp_tx[i]) stream_ok = 1'b0;
    n_cmp++;
    if (!stream_ok) begin
      n_bad++; $display("FAIL random_stream: got %0d bytes expected %0d (or byte differs)",
                        tx_log.size() - n0, exp_tx.size());
    end
  endtask

  initial begin
    test_reset();
    test_read(3'd0, 8'h08, 2);
    test_write(3'd1, 8'hAA);
    test_backpressure(3'd4, 8'h5A);
    test_stray_rx();
    test_back_to_back();
    test_timeout();
    test_reset_abort();
    test_read(3'd6, 8'hB4, 0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/command_initiator.md
# command_initiator

Host-side counterpart of the UART register command manager. It accepts register read/write requests from a local master and serializes them into command/data bytes for the UART transmitter. For reads, it waits for the single response byte from the UART receiver and returns it. It sits between a test or host controller and the UART TX/RX byte interfaces.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles to wait for a read response before reporting a timeout; legal range is 2 or more.
- `i_clk` in 1: the single clock; all logic is on the rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: block can accept a request; high only in IDLE.
- `i_req_rw` in 1: 1 = write, 0 = read.
- `i_req_addr` in 3: register address.
- `i_req_wdata` in 8: write data, sampled at acceptance.
- `o_tx_data` out 8: byte to the UART TX.
- `o_tx_data_valid` out 1: byte valid; held until transferred.
- `i_tx_ready` in 1: UART TX can take a byte.
- `i_rx_data` in 8: byte from the UART RX.
- `i_rx_data_valid` in 1: single-cycle strobe for `i_rx_data`.
- `o_rsp_valid` out 1: single-cycle completion strobe.
- `o_rsp_data` out 8: read data; 0x00 for writes and timeouts.
- `o_rsp_timeout` out 1: qualifies `o_rsp_valid`; the read timed out.

## Operation
- Command byte format is `{4'b0000, addr[2:0], rw}`. Example: a read of address 2 is 0x04; a write of address 1 is 0x03.
- A request is accepted when `i_req_valid & o_req_ready` at a clock edge. The block latches rw, addr and wdata at that point.
- A TX transfer happens at any edge where `o_tx_data_valid & i_tx_ready`. `o_tx_data` is stable while valid is high.
- State machine:
  - IDLE -> SEND_CMD on accept.
  - SEND_CMD: presents the command byte. On transfer, goes to SEND_DATA if writing, otherwise WAIT_RSP.
  - SEND_DATA: presents wdata. On transfer, goes to DONE.
  - WAIT_RSP: the first `i_rx_data_valid` captures `i_rx_data` and moves to DONE. Timeout (see Configuration) moves to DONE with the timeout flag set.
  - DONE: drives `o_rsp_valid` = 1 for one cycle, then returns to IDLE.
- `i_rx_data_valid` is ignored in every state except WAIT_RSP. Bytes received early or stray bytes are dropped.
- New requests are not accepted until the block is back in IDLE. There is no queuing.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`. It clears on entry to WAIT_RSP and increments every WAIT_RSP cycle with no rx strobe.
- A timeout fires on the WAIT_RSP cycle where the counter equals TIMEOUT_CYCLES-1 and there is no rx strobe.
- If an rx strobe arrives on that same final cycle, the data wins and no timeout is reported.

## Timing
- Reset values: `o_req_ready`=1, `o_tx_data`=0x00, `o_tx_data_valid`=0, `o_rsp_valid`=0, `o_rsp_data`=0x00, `o_rsp_timeout`=0. State is IDLE and the counter is 0.
- Reset asserted mid-operation aborts immediately. `o_tx_data_valid` drops asynchronously, the in-flight request is discarded, and no response is issued.
- Accept at edge N: `o_tx_data_valid` is high from cycle N+1. `o_req_ready` is low from N+1 until one cycle after the DONE cycle.
- Write with `i_tx_ready` held high: command transferred at N+1, data at N+2, `o_rsp_valid` high during cycle N+3, ready again at N+4.
- Read: an rx strobe at edge M gives `o_rsp_valid` with data during cycle M+1.
- `o_rsp_data` and `o_rsp_timeout` hold their values until the next accept, which clears them.

## Configuration
- `COMMAND_INITIATOR_TIMEOUT_EN`:
  - Defined: the timeout counter exists and behaves as above.
  - Undefined: no counter is built and WAIT_RSP waits indefinitely for an rx strobe. `o_rsp_timeout` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Test plan
- Read request addr=0, `i_tx_ready`=1, then inject rx 0x08 -> TX carries exactly one byte, 0x00. `o_rsp_valid` pulses once with `o_rsp_data`=0x08 and `o_rsp_timeout`=0.
- Write request addr=1, wdata=0xAA -> TX carries 0x03 then 0xAA on consecutive cycles. `o_rsp_valid` appears at N+3 with data 0x00 and no rx needed.
- TX backpressure: `i_tx_ready` low for 5 cycles during SEND_CMD, then during SEND_DATA -> valid is held, data is stable, and each byte transfers exactly once.
- With macro defined and TIMEOUT_CYCLES=8, read with no rx -> `o_rsp_valid` with timeout=1, data 0x00, on the 8th WAIT_RSP cycle. A rx strobe on that 8th cycle instead returns data with timeout=0.
- Stray rx 0x55 in IDLE and SEND_CMD, then real response 0x12 -> response is 0x12. A request held during a busy period is accepted only once the block is back in IDLE.
- Reset asserted in SEND_DATA and WAIT_RSP -> outputs return to reset values within the same cycle. No `o_rsp_valid` pulse follows, and the next request completes normally.
